// File: rtl/io_uart_pkg.sv
// io_uart_pkg: shared definitions for the UART blocks.
//   uart_tx_state_t           - transmitter FSM state encoding
//   UART_IDLE_LEVEL           - line level when no frame is on the wire
//   UART_DATA_BITS            - payload bits per frame (8N1)
//   UART_DEFAULT_CLKS_PER_BIT - 50 MHz / 115200 baud
package io_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL           = 1'b1;
  localparam int   UART_DATA_BITS            = 8;
  localparam int   UART_DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: free-running 0..CLKS_PER_BIT-1 counter that marks the
// last clock of every bit period.
//   clk, reset - clock, synchronous active-high reset
//   clear      - hold the count at 0 (restarts a bit period next cycle)
//   bit_done   - high on the final cycle of a bit period
import io_uart_pkg::*;

module uart_baud_counter #(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("uart_baud_counter: CLKS_PER_BIT must be >= 2");
    end
  endgenerate

  localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear overrides a boundary so the caller always gets a full period.
  assign bit_done = !clear && (cnt_q == CNT_LAST);

endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: drains the core's output byte buffer onto an 8N1 UART line,
// LSB first, one pop per frame.
//   clk, reset  - clock, synchronous active-high reset
//   buf_avail   - bytes waiting in the output buffer
//   buf_data    - head-of-buffer byte (valid while buf_avail != 0)
//   buf_pop     - one-cycle pop strobe back to the buffer
//   tx          - serial line, idles high
//   busy        - a frame is being fetched or is on the line
//   bytes_sent  - count of completed frames (wraps)
import io_uart_pkg::*;

module io_uart_tx #(
  parameter int CLKS_PER_BIT    = UART_DEFAULT_CLKS_PER_BIT,
  parameter int BUF_COUNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [BUF_COUNT_WIDTH-1:0] buf_avail,
  input  logic [7:0]                 buf_data,
  output logic                       buf_pop,
  output logic                       tx,
  output logic                       busy,
  output logic [31:0]                bytes_sent
);

  uart_tx_state_t state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [31:0]    bytes_sent_q, bytes_sent_d;
  logic           tx_q, tx_d;
  logic           buf_pop_q, buf_pop_d;
  logic           busy_q, busy_d;
  logic           baud_clear;
  logic           bit_done;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (baud_clear),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    bytes_sent_d = bytes_sent_q;
    buf_pop_d    = 1'b0;
    baud_clear   = 1'b0;

    case (state_q)
      IDLE: begin
        baud_clear = 1'b1;
        if (buf_avail != '0) begin
          shift_d   = buf_data;
          buf_pop_d = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        // buf_pop_q is high during this cycle; the buffer drops the byte
        // at the closing edge. Start the bit timing from zero.
        baud_clear = 1'b1;
        bit_cnt_d  = '0;
        state_d    = START;
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          bytes_sent_d = bytes_sent_q + 32'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the current state, so the registered tx trails the
    // state by one cycle; every bit still lasts exactly CLKS_PER_BIT cycles.
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = UART_IDLE_LEVEL;
    endcase

    // Covers the FETCH cycle up front and the trailing cycle of the stop bit.
    busy_d = (state_q != IDLE) || (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      bytes_sent_q <= '0;
      tx_q         <= UART_IDLE_LEVEL;
      buf_pop_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      bytes_sent_q <= bytes_sent_d;
      tx_q         <= tx_d;
      buf_pop_q    <= buf_pop_d;
      busy_q       <= busy_d;
    end
  end

  assign tx         = tx_q;
  assign buf_pop    = buf_pop_q;
  assign busy       = busy_q;
  assign bytes_sent = bytes_sent_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: directed bench for io_uart_tx at CLKS_PER_BIT = 4, with a
// small FIFO model standing in for the core's output buffer.
module tb_io_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] buf_avail = '0;
  logic [7:0]  buf_data = '0;
  logic        buf_pop;
  logic        tx;
  logic        busy;
  logic [31:0] bytes_sent;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Buffer model: bench pushes via wr_ptr, DUT pops via rd_ptr.
  logic [7:0]  mem [0:15];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_cnt = 0;
  int          dbl_pop = 0;
  logic        pop_prev = 1'b0;
  logic        jam = 1'b0;
  logic [31:0] jam_avail = '0;
  logic [7:0]  jam_data = '0;

  io_uart_tx #(
    .CLKS_PER_BIT   (CPB),
    .BUF_COUNT_WIDTH(32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .buf_avail (buf_avail),
    .buf_data  (buf_data),
    .buf_pop   (buf_pop),
    .tx        (tx),
    .busy      (busy),
    .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    pop_prev <= buf_pop;
    if (buf_pop === 1'b1) begin
      pop_cnt <= pop_cnt + 1;
      if (pop_prev === 1'b1) dbl_pop <= dbl_pop + 1;
      if (wr_ptr != rd_ptr) rd_ptr <= rd_ptr + 1;
    end
  end

  // Present the buffer's head/count shortly after each edge.
  always @(posedge clk) begin
    #1;
    if (jam) begin
      buf_avail = jam_avail;
      buf_data  = jam_data;
    end else begin
      buf_avail = 32'(wr_ptr - rd_ptr);
      buf_data  = (wr_ptr != rd_ptr) ? mem[rd_ptr % 16] : 8'h00;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    wr_ptr++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait (bounded) for the start bit, then sample each bit mid-period.
  task automatic rx_byte(input string tag, output logic [7:0] b, output int st);
    int n;
    n  = 0;
    b  = '0;
    st = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      check_eq({tag, "_start_timeout"}, 32'd0, 32'd1);
      return;
    end
    st = cyc;
    repeat (CPB / 2) @(negedge clk);
    check_eq({tag, "_start_mid"}, {31'd0, tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    check_eq({tag, "_stop_mid"}, {31'd0, tx}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic [9:0] frame;
    int st0, st1, st2, pops0, lows, n;

    // 1. Reset and idle with an empty buffer.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_pop", {31'd0, buf_pop}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_bytes", bytes_sent, 32'd0);
    lows = 0;
    pops0 = pop_cnt;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check_eq("idle_tx_low_cycles", 32'(lows), 32'd0);
    check_eq("idle_pops", 32'(pop_cnt - pops0), 32'd0);

    // 2. Single byte 8'hA5: pop latency and exact line waveform.
    pops0 = pop_cnt;
    push(8'hA5);
    @(posedge clk);
    #2;
    @(negedge clk);
    check_eq("a5_pop_before", {31'd0, buf_pop}, 32'd0);
    @(negedge clk);
    check_eq("a5_pop_high", {31'd0, buf_pop}, 32'd1);
    check_eq("a5_busy_fetch", {31'd0, busy}, 32'd1);
    check_eq("a5_tx_fetch", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check_eq("a5_pop_low", {31'd0, buf_pop}, 32'd0);
    check_eq("a5_tx_prestart", {31'd0, tx}, 32'd1);
    frame = 10'b1_1010_0101_0;  // stop, A5 MSB..LSB, start (bit 0 sent first)
    for (int i = 0; i < 10; i++) begin
      lows = 0;
      for (int k = 0; k < CPB; k++) begin
        @(negedge clk);
        if (tx !== frame[i]) lows++;
      end
      check_eq($sformatf("a5_bit%0d_errs", i), 32'(lows), 32'd0);
    end
    check_eq("a5_bytes", bytes_sent, 32'd1);
    repeat (3) @(negedge clk);
    check_eq("a5_busy_after", {31'd0, busy}, 32'd0);
    check_eq("a5_pops", 32'(pop_cnt - pops0), 32'd1);

    // 3. Back-to-back frames from a three-byte buffer.
    do_reset();
    pops0 = pop_cnt;
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    rx_byte("b2b0", b, st0);
    check_eq("b2b0_data", {24'd0, b}, 32'h00);
    rx_byte("b2b1", b, st1);
    check_eq("b2b1_data", {24'd0, b}, 32'hFF);
    rx_byte("b2b2", b, st2);
    check_eq("b2b2_data", {24'd0, b}, 32'h55);
    check_eq("b2b_gap01", 32'(st1 - st0), 32'(10 * CPB + 2));
    check_eq("b2b_gap12", 32'(st2 - st1), 32'(10 * CPB + 2));
    repeat (4) @(negedge clk);
    check_eq("b2b_bytes", bytes_sent, 32'd3);
    check_eq("b2b_pops", 32'(pop_cnt - pops0), 32'd3);

    // 4. Reset during the 4th data bit of 8'h3C.
    pops0 = pop_cnt;
    push(8'h3C);
    n = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_start_seen", {31'd0, (n < 2000)}, 32'd1);
    repeat (4 * CPB + 1) @(negedge clk);
    check_eq("mid_bit3", {31'd0, tx}, 32'd1);
    check_eq("mid_bytes_before", bytes_sent, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_tx", {31'd0, tx}, 32'd1);
    check_eq("mid_rst_bytes", bytes_sent, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check_eq("mid_idle_low_cycles", 32'(lows), 32'd0);
    check_eq("mid_pops", 32'(pop_cnt - pops0), 32'd1);

    // 5. Buffer inputs change during DATA; the latched byte must go out.
    pops0 = pop_cnt;
    jam_avail = 32'd7;
    jam_data  = 8'h0F;
    push(8'h96);
    fork
      rx_byte("stab", b, st0);
      begin
        n = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 2000) begin
          @(negedge clk);
          n++;
        end
        repeat (10) @(negedge clk);
        jam = 1'b1;
        repeat (20) @(negedge clk);
        jam = 1'b0;
      end
    join
    check_eq("stab_data", {24'd0, b}, 32'h96);
    repeat (20) @(negedge clk);
    check_eq("stab_pops", 32'(pop_cnt - pops0), 32'd1);
    check_eq("stab_bytes", bytes_sent, 32'd1);

    // 6. bytes_sent wraps from all-ones to zero.
    force dut.bytes_sent_q = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    release dut.bytes_sent_q;
    @(negedge clk);
    check_eq("wrap_preset", bytes_sent, 32'hFFFF_FFFF);
    push(8'h81);
    rx_byte("wrap", b, st0);
    check_eq("wrap_data", {24'd0, b}, 32'h81);
    repeat (4) @(negedge clk);
    check_eq("wrap_bytes", bytes_sent, 32'd0);

    check_eq("no_double_pop", 32'(dbl_pop), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

Serial transmitter that drains the core's external output byte buffer onto an 8N1 UART line. It sits directly downstream of the core's `io_output_*` port. It watches the buffer's available-byte count, pops one byte at a time through the `io_output_en` strobe, and shifts each byte out LSB-first. It also exports a busy flag and a sent-byte counter for the board top level and for testbenches.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434 — clock cycles per UART bit (50 MHz / 115200). Legal range is ≥ 2; elaboration fails otherwise.
- `BUF_COUNT_WIDTH`, default 32 — width of the buffer-available count.

Ports:
- `clk`  in  1  — clock.
- `reset`  in  1  — synchronous, active-high.
- `buf_avail`  in  BUF_COUNT_WIDTH  — bytes currently in the output buffer; connects to `io_buffer_size_avai`.
- `buf_data`  in  8  — head-of-buffer byte; connects to `io_output_data`. Valid whenever `buf_avail != 0`.
- `buf_pop`  out  1  — one-cycle pop strobe; connects to `io_output_en`. The buffer removes the head byte at the rising edge where `buf_pop` is 1.
- `tx`  out  1  — UART line; idles high.
- `busy`  out  1  — high from the FETCH state through the end of the stop bit.
- `bytes_sent`  out  32  — number of completed frames.

## Operation
- FSM states: IDLE, FETCH, START, DATA, STOP.
- **IDLE**
  - `tx`=1, `busy`=0.
  - If `buf_avail != 0`: latch `buf_data` into an 8-bit shift register, set `buf_pop`<=1, go to FETCH.
- **FETCH**
  - `buf_pop` is high for exactly this cycle; the buffer pops at the closing edge.
  - Clear the bit counter and baud counter, go to START.
- **START**
  - `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA**
  - `tx` = shift[0] for CLKS_PER_BIT cycles per bit.
  - Shift right at each bit boundary.
  - After 8 bits, go to STOP.
- **STOP**
  - `tx`=1 for CLKS_PER_BIT cycles.
  - At the final cycle, `bytes_sent` <= `bytes_sent` + 1 (wraps modulo 2^32), then go to IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1. The bit boundary is at count == CLKS_PER_BIT-1.
- `buf_avail` is sampled only in IDLE. Changes in other states are ignored.
- `buf_data` is sampled only on the IDLE→FETCH edge.

## Timing
- All outputs are registered.
- Reset values: `tx`=1, `buf_pop`=0, `busy`=0, `bytes_sent`=0, state IDLE, shift register 0, counters 0.
- Latency from `buf_avail` becoming nonzero (sampled at edge N):
  - `buf_pop`=1 during cycle N+1.
  - The start bit begins at edge N+2.
- A frame is exactly 10×CLKS_PER_BIT cycles of line time.
- Back-to-back bytes:
  - Each frame occupies 10×CLKS_PER_BIT + 2 cycles from one start-bit edge to the next.
  - The stop bit is therefore effectively CLKS_PER_BIT+2 cycles long (IDLE and FETCH hold `tx` high).
- `buf_pop` is never high on two consecutive cycles. There is at most one pop per frame.
- An empty buffer (`buf_avail`=0) holds the FSM in IDLE indefinitely with `tx`=1 and no pop.
- A buffer count that goes stale by one cycle after a pop is harmless: the count is next sampled ≥ 10×CLKS_PER_BIT cycles later.
- Reset mid-frame:
  - `tx` returns to 1 at the next edge.
  - The in-flight byte is dropped; it was already popped and is not re-popped.
  - `bytes_sent` clears.
- Reset while in FETCH: `buf_pop` deasserts at that edge. The pop still occurs, because the buffer sampled it before reset took effect.

## Structure
- Shared package `io_uart_pkg`:
  - State enum `uart_tx_state_t` (IDLE, FETCH, START, DATA, STOP).
  - Constants `UART_IDLE_LEVEL`=1, `UART_DATA_BITS`=8, `UART_DEFAULT_CLKS_PER_BIT`=434.
- One sub-module: `uart_baud_counter`.
  - Parameterised by CLKS_PER_BIT.
  - Inputs: `clk`, `reset`, `clear`.
  - Output: `bit_done` pulse.
  - Also reusable by a future receiver.
- Main module holds the FSM, shift register, bit counter (3 bits) and `bytes_sent`.

## Test plan
Benches run with CLKS_PER_BIT=4.
1. **Reset:** hold `reset` 3 cycles, `buf_avail`=0 → `tx`=1, `buf_pop`=0, `busy`=0, `bytes_sent`=0. 200 idle cycles → no pop, `tx` stays 1.
2. **Single byte:** `buf_avail`=1, `buf_data`=8'hA5.
   - Expected: `buf_pop` is one cycle high 1 cycle later.
   - `tx` sequence, 4 cycles each: 0,1,0,1,0,0,1,0,1,1.
   - `bytes_sent`=1. Exactly 1 pop.
3. **Back-to-back:** a buffer model holding 3 bytes 8'h00, 8'hFF, 8'h55.
   - Expected: 3 pops, start bits spaced 42 cycles apart.
   - Decoded bytes match, in order. `bytes_sent`=3.
4. **Reset mid-frame:** assert `reset` during the 4th data bit of 8'h3C → `tx`=1 the next cycle, `bytes_sent`=0, no re-pop while `buf_avail`=0.
5. **Input stability:** change `buf_data` and `buf_avail` during DATA → the transmitted byte equals the value latched at FETCH, and no extra pop occurs.
6. **Counter wrap:** force `bytes_sent`=32'hFFFF_FFFF, send one byte → `bytes_sent`=0.
